alu_multicycle_exec: RTL

//  Execute-stage ALU that consumes the 4-bit Operation code produced by ALUController plus two operands, and returns a result and zero flag.
//  Add, sub, logic and compare complete in one cycle; shifts iterate one bit per cycle to save area.

---
 rtl/alu_op_pkg.sv | 21 ++
 rtl/alu_comb_core.sv | 27 ++
 rtl/alu_multicycle_exec.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Shared ALU operation encoding, also imported by ALUController so both blocks agree on opcodes.
package alu_op_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0011,
      ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101,
      ALU_SRA = 4'b0110,
      ALU_EQ  = 4'b1000,
      ALU_XOR = 4'b1001,
      ALU_SLT = 4'b1100
   } alu_op_e;

   function automatic logic is_shift(input alu_op_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU functions; shift codes and unused codes return 0 here (shifts are iterated by the top).
module alu_comb_core
   import alu_op_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_e           i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result
);

   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         ALU_XOR: o_result = i_a ^ i_b;
         ALU_EQ:  o_result = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
         ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU with valid/ready on both sides; shifts advance one bit per cycle.
//    state | meaning
//    IDLE  | empty, ready to accept an op
//    SHIFT | iterating a shift, input stalled
//    DONE  | result presented, held until out_ready
module alu_multicycle_exec
   import alu_op_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        operation,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_exec_state_e;

   alu_exec_state_e     r_state;
   alu_exec_state_e     w_next_state;
   alu_op_e             r_op;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_result;
   logic [SHAMT_W-1:0]  r_cnt;
   logic                r_zero;

   alu_op_e             w_op;
   logic [SHAMT_W-1:0]  w_shamt;
   logic                w_accept;
   logic                w_start_shift;
   logic                w_last_shift;
   logic                w_load_result;
   logic                w_in_ready;
   logic                w_out_valid;
   logic [DATA_W-1:0]   w_comb_result;
   logic [DATA_W-1:0]   w_shift_step;
   logic [DATA_W-1:0]   w_result_d;

   function automatic logic [DATA_W-1:0] shift_one(input alu_op_e op, input logic [DATA_W-1:0] v);
      case (op)
         ALU_SLL: shift_one = {v[DATA_W-2:0], 1'b0};
         ALU_SRL: shift_one = {1'b0, v[DATA_W-1:1]};
         default: shift_one = {v[DATA_W-1], v[DATA_W-1:1]};
      endcase
   endfunction

   assign w_op          = alu_op_e'(operation);
   assign w_shamt       = op_b[SHAMT_W-1:0];
   assign w_accept      = in_valid & w_in_ready;
   assign w_start_shift = w_accept & is_shift(w_op) & (w_shamt != '0);
   assign w_last_shift  = (r_state == SHIFT) && (r_cnt == SHAMT_W'(1));
   assign w_shift_step  = shift_one(r_op, r_acc);
   assign w_load_result = (w_accept & ~w_start_shift) | (w_last_shift & ~flush);

   alu_comb_core #(
      .DATA_W (DATA_W)
   ) u_comb_core (
      .i_op     (w_op),
      .i_a      (op_a),
      .i_b      (op_b),
      .o_result (w_comb_result)
   );

   // A shift with zero amount completes immediately and passes op_a through.
   always_comb begin
      w_result_d = w_comb_result;
      if (w_last_shift) begin
         w_result_d = w_shift_step;
      end else if (is_shift(w_op)) begin
         w_result_d = op_a;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_next_state = w_start_shift ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               if (w_last_shift) begin
                  w_next_state = DONE;
               end
            end
            DONE: begin
               if (w_accept) begin
                  w_next_state = w_start_shift ? SHIFT : DONE;
               end else if (out_ready) begin
                  w_next_state = IDLE;
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: w_in_ready = ~flush;
         DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = out_ready & ~flush;
         end
         default: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_op     <= ALU_AND;
      end else begin
         if (w_load_result) begin
            r_result <= w_result_d;
            r_zero   <= (w_result_d == '0);
         end
         if (flush) begin
            r_cnt <= '0;
         end else if (w_start_shift) begin
            r_acc <= op_a;
            r_cnt <= w_shamt;
            r_op  <= w_op;
         end else if (r_state == SHIFT) begin
            r_acc <= w_shift_step;
            r_cnt <= r_cnt - SHAMT_W'(1);
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;

endmodule
